// File: rtl/mappy_obj_sched.sv
// mappy_obj_sched: per-line sprite scan scheduler.
// During hblank it walks the sprite attribute table (two byte offsets per
// entry, three parallel RAM read ports, one-cycle read latency), tests each
// sprite's Y range against the line being prepared and queues the matches,
// in table order, into a first-word-fall-through FIFO drained by the
// rasteriser.
//
// Handshake: spr_valid is high whenever the FIFO holds an entry; the head
// fields are stable while spr_valid is high and spr_ready is low; a pop
// happens on any rising edge where spr_valid & spr_ready.
module mappy_obj_sched #(
  parameter int NUM_OBJ    = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_36864,
  input  logic       reset,
  input  logic       line_start,
  input  logic [7:0] vline,
  output logic [6:0] obj_addr,
  input  logic [7:0] obj1_in,
  input  logic [7:0] obj2_in,
  input  logic [7:0] obj3_in,
  output logic       spr_valid,
  input  logic       spr_ready,
  output logic [7:0] spr_tile,
  output logic [5:0] spr_pal,
  output logic [8:0] spr_x,
  output logic [4:0] spr_row,
  output logic       spr_flipx,
  output logic [1:0] spr_size,
  output logic       scan_busy,
  output logic       scan_done,
  output logic       overflow,
  output logic [6:0] match_cnt,
  output logic [2:0] dbg_state
);

  // Entry index is 6 bits so that {idx, lsb} forms the 7-bit byte offset.
  localparam int IW = 6;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 31;  // tile8 + pal6 + x9 + row5 + flipx1 + size2

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A0   = 3'd1,
    S_A1   = 3'd2,
    S_EV   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    vline_q;

  // Even-byte fields captured in A1, consumed in EV.
  logic [7:0]    tile_q;
  logic [7:0]    ypos_q;
  logic          flipx_q;
  logic          flipy_q;
  logic [1:0]    size_q;

  // FIFO storage and pointers.
  logic [RW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic          overflow_q;
  logic [6:0]    match_cnt_q;

  // Evaluation datapath.
  logic          tall;
  logic [8:0]    y;
  logic          y_hit;
  logic          is_ev;
  logic          match;
  logic [4:0]    row_raw;
  logic [4:0]    row;
  logic [RW-1:0] new_rec;
  logic [RW-1:0] head;
  logic          push;
  logic          pop;
  logic          drop;
  logic          unused_bits;

  // Upper attribute bits of obj3 carry nothing this block needs.
  assign unused_bits = ^obj3_in[7:4];

  // Next-state logic; line_start restarts the scan from any state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: ;
      S_A0:   state_d = S_A1;
      S_A1:   state_d = S_EV;
      S_EV: begin
        if (idx_q == IW'(NUM_OBJ - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_A0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (line_start) begin
      state_d = S_A0;
      idx_d   = '0;
    end
  end

  // State, entry index and latched line register.
  always_ff @(posedge clk_36864) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vline_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (line_start) vline_q <= vline;
    end
  end

  // Capture the even-byte fields when their read data arrives (in A1).
  always_ff @(posedge clk_36864) begin
    if (reset) begin
      tile_q  <= '0;
      ypos_q  <= '0;
      flipx_q <= 1'b0;
      flipy_q <= 1'b0;
      size_q  <= '0;
    end else if (state_q == S_A1) begin
      tile_q  <= obj1_in;
      ypos_q  <= obj2_in;
      flipx_q <= obj3_in[0];
      flipy_q <= obj3_in[1];
      size_q  <= obj3_in[3:2];
    end
  end

  // Y range test and row computation; odd-byte fields are on the inputs in EV.
  always_comb begin
    tall    = size_q[1];
    y       = {1'b0, ypos_q} + {1'b0, vline_q} + (tall ? 9'd16 : 9'd0) - 9'd1;
    y_hit   = tall ? (y[8:5] == 4'b0111) : (y[8:4] == 5'b01110);
    // An aborting line_start in EV suppresses the push for the old scan.
    is_ev   = (state_q == S_EV) && !line_start;
    match   = is_ev && !obj3_in[1] && y_hit;
    row_raw = tall ? y[4:0] : {1'b0, y[3:0]};
    row     = row_raw ^ (flipy_q ? (tall ? 5'h1f : 5'h0f) : 5'h00);
    new_rec = {tile_q, obj1_in[5:0], obj3_in[0], obj2_in, row, flipx_q, size_q};
  end

  // FIFO control: a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    pop  = spr_valid && spr_ready;
    push = match && ((count_q < (AW+1)'(FIFO_DEPTH)) || pop);
    drop = match && !push;
  end

  // FIFO pointers and occupancy; line_start discards anything queued.
  always_ff @(posedge clk_36864) begin
    if (reset || line_start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the valid-gated head.
  always_ff @(posedge clk_36864) begin
    if (push) mem_q[wr_ptr_q] <= new_rec;
  end

  // Per-line match counter (saturating) and sticky drop flag.
  always_ff @(posedge clk_36864) begin
    if (reset || line_start) begin
      overflow_q  <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      if (drop) overflow_q <= 1'b1;
      if (match && (match_cnt_q != 7'h7f)) match_cnt_q <= match_cnt_q + 1'b1;
    end
  end

  // Output decode; head fields read as zero while the FIFO is empty.
  always_comb begin
    spr_valid = (count_q != '0);
    head      = spr_valid ? mem_q[rd_ptr_q] : '0;
    spr_tile  = head[30:23];
    spr_pal   = head[22:17];
    spr_x     = head[16:8];
    spr_row   = head[7:3];
    spr_flipx = head[2];
    spr_size  = head[1:0];
    obj_addr  = ((state_q == S_A0) || (state_q == S_A1))
                ? {idx_q, (state_q == S_A1)} : 7'd0;
    scan_busy = (state_q == S_A0) || (state_q == S_A1) || (state_q == S_EV);
    scan_done = (state_q == S_DONE);
    overflow  = overflow_q;
    match_cnt = match_cnt_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mappy_obj_sched.sv
// Bench for mappy_obj_sched: attribute table model with 1-cycle read latency,
// directed scans, and a scoreboard of expected sprite records.
module tb_mappy_obj_sched;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_A0   = 3'd1;
  localparam logic [2:0] ST_A1   = 3'd2;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       line_start;
  logic [7:0] vline;
  logic [6:0] obj_addr;
  logic [7:0] obj1_in, obj2_in, obj3_in;
  logic       spr_valid;
  logic       spr_ready;
  logic [7:0] spr_tile;
  logic [5:0] spr_pal;
  logic [8:0] spr_x;
  logic [4:0] spr_row;
  logic       spr_flipx;
  logic [1:0] spr_size;
  logic       scan_busy;
  logic       scan_done;
  logic       overflow;
  logic [6:0] match_cnt;
  logic [2:0] dbg_state;

  mappy_obj_sched dut (
    .clk_36864 (clk),
    .reset     (reset),
    .line_start(line_start),
    .vline     (vline),
    .obj_addr  (obj_addr),
    .obj1_in   (obj1_in),
    .obj2_in   (obj2_in),
    .obj3_in   (obj3_in),
    .spr_valid (spr_valid),
    .spr_ready (spr_ready),
    .spr_tile  (spr_tile),
    .spr_pal   (spr_pal),
    .spr_x     (spr_x),
    .spr_row   (spr_row),
    .spr_flipx (spr_flipx),
    .spr_size  (spr_size),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .overflow  (overflow),
    .match_cnt (match_cnt),
    .dbg_state (dbg_state)
  );

  // Attribute table with one-cycle read latency
  logic [7:0] tbl1 [128];
  logic [7:0] tbl2 [128];
  logic [7:0] tbl3 [128];

  always @(posedge clk) begin
    obj1_in <= tbl1[obj_addr];
    obj2_in <= tbl2[obj_addr];
    obj3_in <= tbl3[obj_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [30:0] head;
  assign head = {spr_tile, spr_pal, spr_x, spr_row, spr_flipx, spr_size};

  // Scoreboard
  logic [30:0] exp_q [$];
  int vectors     = 0;
  int miscompares = 0;
  int t0, done_cnt, done_cyc, first_valid, busy_cnt, valid_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [30:0] rec(input logic [7:0] t, input logic [5:0] p,
                                      input logic [8:0] x, input logic [4:0] r,
                                      input logic fx, input logic [1:0] sz);
    return {t, p, x, r, fx, sz};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic observe();
    if (spr_valid) begin
      valid_cnt++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (spr_valid && spr_ready) begin
      if (exp_q.size() == 0) check("spurious_pop_valid", 32'(spr_valid), 32'd0);
      else check("pop_record", 32'(head), 32'(exp_q.pop_front()));
    end
    if (scan_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (scan_busy) busy_cnt++;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      observe();
      tick();
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < 64; i++) begin
      tbl1[2*i]   = 8'($urandom);
      tbl2[2*i]   = 8'($urandom);
      tbl3[2*i]   = 8'($urandom);
      tbl1[2*i+1] = 8'($urandom);
      tbl2[2*i+1] = 8'($urandom);
      tbl3[2*i+1] = 8'($urandom) | 8'h02;  // disabled
    end
  endtask

  task automatic set_entry(input int i, input logic [7:0] tile, input logic [7:0] ypos,
                           input logic fx, input logic fy, input logic [1:0] sz,
                           input logic [5:0] pal, input logic [8:0] x9);
    tbl1[2*i]   = tile;
    tbl2[2*i]   = ypos;
    tbl3[2*i]   = {4'h0, sz, fy, fx};
    tbl1[2*i+1] = {2'b00, pal};
    tbl2[2*i+1] = x9[7:0];
    tbl3[2*i+1] = {7'h00, x9[8]};
  endtask

  // 20 matching entries at indices 0,3,...,57 for vline 0xC5.
  task automatic setup_twenty();
    logic tall;
    logic [7:0] yp;
    clear_table();
    for (int k = 0; k < 20; k++) begin
      tall = 1'($urandom_range(0, 1));
      yp   = tall ? 8'(8'h0C + $urandom_range(0, 31)) : 8'(8'h1C + $urandom_range(0, 15));
      set_entry(3*k, 8'($urandom), yp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {tall, 1'($urandom_range(0, 1))}, 6'($urandom), 9'($urandom));
    end
  endtask

  // Reference model of one scan over the table; queues at most cap records.
  task automatic model_scan(input logic [7:0] v, input int cap, output int n);
    logic [7:0] e1, e2, e3, o1, o2, o3;
    logic [8:0] y;
    logic tall, hit;
    logic [4:0] r;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      e1 = tbl1[2*i]; e2 = tbl2[2*i]; e3 = tbl3[2*i];
      o1 = tbl1[2*i+1]; o2 = tbl2[2*i+1]; o3 = tbl3[2*i+1];
      tall = e3[3];
      y = 9'(e2) + 9'(v) + (tall ? 9'd16 : 9'd0) - 9'd1;
      hit = tall ? (y[8:5] == 4'b0111) : (y[8:4] == 5'b01110);
      if (!o3[1] && hit) begin
        r = tall ? y[4:0] : {1'b0, y[3:0]};
        if (e3[1]) r = r ^ (tall ? 5'h1f : 5'h0f);
        if (n < cap) exp_q.push_back(rec(e1, o1[5:0], {o3[0], o2}, r, e3[0], e3[3:2]));
        n++;
      end
    end
  endtask

  task automatic start_scan(input logic [7:0] v);
    vline      = v;
    line_start = 1'b1;
    t0         = cyc;
    done_cnt = 0; done_cyc = -1; first_valid = -1; busy_cnt = 0; valid_cnt = 0;
    tick();
    line_start = 1'b0;
  endtask

  // Full scan with timing checks on entry, address sequence and completion.
  task automatic scan_and_wait(input string tag, input logic [7:0] v);
    start_scan(v);
    check({tag, "_state_t1"}, 32'(dbg_state), 32'(ST_A0));
    check({tag, "_addr_t1"}, 32'(obj_addr), 32'd0);
    run(1);
    check({tag, "_state_t2"}, 32'(dbg_state), 32'(ST_A1));
    check({tag, "_addr_t2"}, 32'(obj_addr), 32'd1);
    run(199);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_done_cyc"}, 32'(done_cyc - t0), 32'd193);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd192);
    check({tag, "_state_end"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_obj_addr"}, 32'(obj_addr), 32'd0);
    check({tag, "_spr_valid"}, 32'(spr_valid), 32'd0);
    check({tag, "_spr_fields"}, 32'(head), 32'd0);
    check({tag, "_scan_busy"}, 32'(scan_busy), 32'd0);
    check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_match_cnt"}, 32'(match_cnt), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  int n;

  initial begin
    reset = 1'b1; line_start = 1'b0; vline = 8'h00; spr_ready = 1'b0;
    clear_table();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("rst");

    // All entries disabled
    spr_ready = 1'b1;
    scan_and_wait("dis", 8'hC5);
    check("dis_valid_cycles", 32'(valid_cnt), 32'd0);
    check("dis_match_cnt", 32'(match_cnt), 32'd0);
    check("dis_overflow", 32'(overflow), 32'd0);

    // Entry 5, short, no flip
    clear_table();
    set_entry(5, 8'h7A, 8'h20, 1'b0, 1'b0, 2'b00, 6'h11, 9'h134);
    exp_q.push_back(rec(8'h7A, 6'h11, 9'h134, 5'h04, 1'b0, 2'b00));
    scan_and_wait("e5", 8'hC5);
    check("e5_first_valid", 32'(first_valid - t0), 32'd19);
    check("e5_q_empty", 32'(exp_q.size()), 32'd0);
    check("e5_match_cnt", 32'(match_cnt), 32'd1);
    check("e5_overflow", 32'(overflow), 32'd0);

    // Entry 5, flipy
    set_entry(5, 8'h7A, 8'h20, 1'b0, 1'b1, 2'b00, 6'h11, 9'h134);
    exp_q.push_back(rec(8'h7A, 6'h11, 9'h134, 5'h0B, 1'b0, 2'b00));
    scan_and_wait("e5f", 8'hC5);
    check("e5f_q_empty", 32'(exp_q.size()), 32'd0);

    // Entry 9, tall, no flip then flipy
    clear_table();
    set_entry(9, 8'h55, 8'h10, 1'b1, 1'b0, 2'b10, 6'h2A, 9'h0FF);
    exp_q.push_back(rec(8'h55, 6'h2A, 9'h0FF, 5'h04, 1'b1, 2'b10));
    scan_and_wait("e9", 8'hC5);
    check("e9_q_empty", 32'(exp_q.size()), 32'd0);
    check("e9_first_valid", 32'(first_valid - t0), 32'd31);
    set_entry(9, 8'h55, 8'h10, 1'b1, 1'b1, 2'b10, 6'h2A, 9'h0FF);
    exp_q.push_back(rec(8'h55, 6'h2A, 9'h0FF, 5'h1B, 1'b1, 2'b10));
    scan_and_wait("e9f", 8'hC5);
    check("e9f_q_empty", 32'(exp_q.size()), 32'd0);

    // Entry 9 with size 0: out of range
    set_entry(9, 8'h55, 8'h10, 1'b1, 1'b0, 2'b00, 6'h2A, 9'h0FF);
    scan_and_wait("e9s0", 8'hC5);
    check("e9s0_valid_cycles", 32'(valid_cnt), 32'd0);
    check("e9s0_match_cnt", 32'(match_cnt), 32'd0);

    // 20 matches, rasteriser stalled: 16 kept, overflow
    setup_twenty();
    spr_ready = 1'b0;
    model_scan(8'hC5, 16, n);
    scan_and_wait("ovf", 8'hC5);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_match_cnt", 32'(match_cnt), 32'd20);
    check("ovf_valid", 32'(spr_valid), 32'd1);
    run(3);
    check("ovf_head_stable", 32'(head), 32'(exp_q[0]));
    spr_ready = 1'b1;
    run(20);
    check("ovf_drained", 32'(exp_q.size()), 32'd0);
    check("ovf_valid_after", 32'(spr_valid), 32'd0);

    // Restart 50 cycles into a scan with entries queued
    spr_ready = 1'b0;
    start_scan(8'hC5);
    run(49);
    check("rs_valid_t50", 32'(spr_valid), 32'd1);
    exp_q.delete();
    model_scan(8'hC5, 16, n);
    start_scan(8'hC5);
    check("rs_valid_t51", 32'(spr_valid), 32'd0);
    check("rs_match_cnt_t51", 32'(match_cnt), 32'd0);
    start_scan_checks_done: begin end
    run(199);
    check("rs_done_cnt", 32'(done_cnt), 32'd1);
    check("rs_done_cyc", 32'(done_cyc - t0), 32'd193);
    check("rs_overflow", 32'(overflow), 32'd1);
    check("rs_match_cnt", 32'(match_cnt), 32'd20);
    spr_ready = 1'b1;
    run(20);
    check("rs_drained", 32'(exp_q.size()), 32'd0);
    check("rs_valid_after", 32'(spr_valid), 32'd0);

    // Reset 100 cycles into a scan
    spr_ready = 1'b0;
    exp_q.delete();
    start_scan(8'hC5);
    run(99);
    check("mr_busy_t100", 32'(scan_busy), 32'd1);
    reset = 1'b1;
    tick();
    check_reset_outputs("mr");
    reset = 1'b0;
    done_cnt = 0; valid_cnt = 0;
    run(200);
    check("mr_no_done", 32'(done_cnt), 32'd0);
    check("mr_no_valid", 32'(valid_cnt), 32'd0);
    check("mr_state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
